cpu_path_scheduler: RTL

//  Shares the path-planning RISC-V core among N_REQ requesters (e.g. pickup/delivery task units).

---
 rtl/cpu_path_scheduler.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_path_scheduler.sv
// Round-robin scheduler sharing one path-planning CPU among N_REQ requesters.
// Each job: latch SP/EP, hold cpu_reset, run until done or timeout, respond, then idle a gap.
//
//   state    | meaning
//   IDLE     | waiting for a request; SP==EP jobs are answered here without a CPU run
//   RST_HOLD | cpu_reset high for RESET_CYCLES cycles, cpu_done ignored
//   RUN      | waiting for cpu_done, bounded by TIMEOUT_CYCLES
//   GAP      | enforced quiet period before the next grant
module cpu_path_scheduler #(
    parameter int N_REQ          = 2,
    parameter int NODE_W         = 8,
    parameter int SIZE_W         = 8,
    parameter int RESET_CYCLES   = 10000,
    parameter int TIMEOUT_CYCLES = 5000000,
    parameter int GAP_CYCLES     = 1000
) (
    input  logic                     clk_50M,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*NODE_W-1:0]  req_sp,
    input  logic [N_REQ*NODE_W-1:0]  req_ep,
    output logic [N_REQ-1:0]         req_ready,
    output logic [NODE_W-1:0]        SP,
    output logic [NODE_W-1:0]        EP,
    output logic                     cpu_reset,
    input  logic                     cpu_done,
    input  logic [SIZE_W-1:0]        cpu_size,
    output logic [N_REQ-1:0]         resp_valid,
    output logic [SIZE_W-1:0]        resp_size,
    output logic                     resp_timeout,
    output logic                     busy,
    output logic [1:0]               state
);

    localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int MAX_RT  = (RESET_CYCLES > TIMEOUT_CYCLES) ? RESET_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_CNT = (MAX_RT > GAP_EFF) ? MAX_RT : GAP_EFF;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RST_HOLD = 2'd1,
        ST_RUN      = 2'd2,
        ST_GAP      = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic [NODE_W-1:0]   sp_q, sp_d;
    logic [NODE_W-1:0]   ep_q, ep_d;
    logic [N_REQ-1:0]    resp_valid_q, resp_valid_d;
    logic [SIZE_W-1:0]   resp_size_q, resp_size_d;
    logic                resp_timeout_q, resp_timeout_d;

    logic                grant_any;
    logic [PTR_W-1:0]    grant_idx;
    logic [NODE_W-1:0]   grant_sp;
    logic [NODE_W-1:0]   grant_ep;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(idx);
            end
        end
    end

    assign grant_sp = req_sp[grant_idx*NODE_W +: NODE_W];
    assign grant_ep = req_ep[grant_idx*NODE_W +: NODE_W];

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        sp_d           = sp_q;
        ep_d           = ep_q;
        resp_valid_d   = '0;
        resp_size_d    = resp_size_q;
        resp_timeout_d = resp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    sp_d     = grant_sp;
                    ep_d     = grant_ep;
                    owner_d  = grant_idx;
                    rr_ptr_d = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    if (grant_sp == grant_ep) begin
                        resp_valid_d   = N_REQ'(1) << grant_idx;
                        resp_size_d    = SIZE_W'(1);
                        resp_timeout_d = 1'b0;
                    end else begin
                        state_d = ST_RST_HOLD;
                        cnt_d   = CNT_W'(RESET_CYCLES - 1);
                    end
                end
            end
            ST_RST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_W'(TIMEOUT_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                // Done takes priority over a timeout landing on the same cycle.
                if (cpu_done) begin
                    resp_valid_d   = N_REQ'(1) << owner_q;
                    resp_size_d    = cpu_size;
                    resp_timeout_d = 1'b0;
                    state_d        = ST_GAP;
                    cnt_d          = CNT_W'(GAP_EFF - 1);
                end else if (cnt_q == '0) begin
                    resp_valid_d   = N_REQ'(1) << owner_q;
                    resp_size_d    = '0;
                    resp_timeout_d = 1'b1;
                    state_d        = ST_GAP;
                    cnt_d          = CNT_W'(GAP_EFF - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            rr_ptr_q       <= '0;
            owner_q        <= '0;
            sp_q           <= '0;
            ep_q           <= '0;
            resp_valid_q   <= '0;
            resp_size_q    <= '0;
            resp_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rr_ptr_q       <= rr_ptr_d;
            owner_q        <= owner_d;
            sp_q           <= sp_d;
            ep_q           <= ep_d;
            resp_valid_q   <= resp_valid_d;
            resp_size_q    <= resp_size_d;
            resp_timeout_q <= resp_timeout_d;
        end
    end

    // Accept pulse is combinational in IDLE; masked while reset is asserted.
    assign req_ready    = (state_q == ST_IDLE && grant_any && !reset) ? (N_REQ'(1) << grant_idx) : '0;
    assign SP           = sp_q;
    assign EP           = ep_q;
    assign cpu_reset    = (state_q == ST_RST_HOLD);
    assign resp_valid   = resp_valid_q;
    assign resp_size    = resp_size_q;
    assign resp_timeout = resp_timeout_q;
    assign busy         = (state_q != ST_IDLE);
    assign state        = state_q;

endmodule
